// File: rtl/add_slice_sequencer.sv
// add_slice_sequencer: one SLICE_W-bit adder shared by two requesters.
// Each request is a W-bit add. It is done over NSLICE cycles, low slice first,
// and the carry is passed from slice to slice through a register.
module add_slice_sequencer #(
  parameter int unsigned SLICE_W = 16,
  parameter int unsigned NSLICE  = 2,
  localparam int unsigned W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout
);

  localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic [IDXW-1:0] idx;
  logic            last_grant;

  logic            grant;
  logic            accept;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_cin;
  int unsigned     base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W:0]   slice_res;

  // Arbitration: the sole valid requester wins; on a tie, whoever did not win last time.
  always_comb begin
    grant  = 1'b0;
    accept = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
    accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_a      = grant ? req1_a   : req0_a;
    sel_b      = grant ? req1_b   : req0_b;
    sel_cin    = grant ? req1_cin : req0_cin;
  end

  // Shared slice adder working on the slice selected by idx.
  always_comb begin
    base      = 32'(idx) * SLICE_W;
    slice_a   = opa[base +: SLICE_W];
    slice_b   = opb[base +: SLICE_W];
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_W + 1)'(carry);
  end

  // Sequencer FSM: capture, add one slice per cycle, hold the result until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa      <= sel_a;
            opb      <= sel_b;
            carry    <= sel_cin;
            idx      <= '0;
            rsp_id   <= grant;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          rsp_sum[base +: SLICE_W] <= slice_res[SLICE_W-1:0];
          carry <= slice_res[SLICE_W];
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            rsp_cout  <= slice_res[SLICE_W];
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            rsp_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_slice_sequencer.sv
// Testbench for add_slice_sequencer (SLICE_W=16, NSLICE=2): directed vectors,
// expectations queued at acceptance and checked by an independent monitor.
module tb_add_slice_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   seen = 0;

  add_slice_sequencer #(.SLICE_W(16), .NSLICE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops on every handshake and checks stability while stalled.
  logic         prev_stall = 1'b0;
  logic [33:0]  prev_rsp = '0;
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && rsp_valid)
          check("stall_stable", {30'd0, rsp_id, rsp_cout, rsp_sum}, {30'd0, prev_rsp});
        if (rsp_valid && rsp_ready) begin
          seen++;
          if (sb.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
            check("rsp_sum", {32'd0, rsp_sum}, {32'd0, e.sum});
            check("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_id, rsp_cout, rsp_sum};
      end
    end
  end

  task automatic drive(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin, input bit v);
    if (who) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = v;
    end
  endtask

  // Present one request, wait (bounded) for its ready, queue the expected response.
  task automatic issue(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                       input bit push, input logic [W-1:0] esum, input bit ecout);
    int n = 0;
    logic rdy;
    @(posedge clk); #1;
    drive(who, a, b, cin, 1'b1);
    do begin
      @(negedge clk);
      n++;
      rdy = who ? req1_ready : req0_ready;
    end while (!rdy && n < 50);
    check("accept", {63'd0, rdy}, 64'd1);
    if (push) sb.push_back('{id: who, sum: esum, cout: ecout});
    @(posedge clk); #1;
    // scramble operands after acceptance; the result must not change
    drive(who, ~a, b ^ 32'h5A5A5A5A, ~cin, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", {63'd0, n >= 100}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("reset_outputs", {rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum},
                           {32'd0, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // reset state
    #2;
    check("reset_outputs", {rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: carry crosses the slice boundary; also latency to rsp_valid
    issue(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 32'h00010000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check("latency", 64'(n), 64'd3);

    // 2, 3: full-width carries and wraparound
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    issue(1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 32'h00000000, 1'b1);
    drain();

    // 4: both requesters held valid -> alternating grants starting with req0
    do_reset();
    @(posedge clk); #1;
    drive(1'b0, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
    drive(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(req0_ready || req1_ready) && n < 50);
      check("arb_grant", {62'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) sb.push_back('{id: 1'b0, sum: 32'h00000003, cout: 1'b0});
      else            sb.push_back('{id: 1'b1, sum: 32'h80000000, cout: 1'b0});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // 5: consumer stalls in DONE while req0 waits
    rsp_ready = 1'b0;
    issue(1'b0, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {61'd0, rsp_valid, req0_ready, req1_ready}, 64'd4);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_in_done", {62'd0, rsp_valid, req0_ready}, 64'd2);
    @(negedge clk);
    check("ready_after_done", {63'd0, req0_ready}, 64'd1);
    sb.push_back('{id: 1'b0, sum: 32'h00000000, cout: 1'b1});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // 6: reset during ADD aborts the operation
    issue(1'b1, 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 32'h0, 1'b0);
    n = seen;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_rsp", 64'(seen), 64'(n));
    issue(1'b1, 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b1, 32'h10101010, 1'b0);
    drain();
    check("queue_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
